// File: rtl/alu_mdu_unit.sv
// alu_mdu_unit: execute-stage ALU with the RV32M multiply/divide set.
//   Decodes alu_op/func7/func3 on accept, captures operands, and produces
//   one registered result per request. Simple ops and the divide early-outs
//   complete in one cycle. MUL/DIV families iterate for XLEN cycles, one
//   bit per cycle, on operand magnitudes.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid/in_ready       request handshake (in_ready only in IDLE)
//   alu_op, func7, func3    instruction fields to decode
//   op_a, op_b              rs1 and rs2/immediate operands
//   out_valid/out_ready     result handshake
//   out_result, out_zero    registered result and its zero flag
//   out_illegal             unsupported encoding (result forced to 0)
//   busy                    high while an iterative op is running
//   dbg_state               current FSM state (0 IDLE, 1 ITER, 2 DONE)
// Handshake: a transfer happens on a rising edge where valid & ready are
// both high; a source holds valid and its payload steady until then, and
// the unit holds out_* steady while out_valid is high and out_ready low.
module alu_mdu_unit #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [6:0]      func7,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_zero,
  output logic            out_illegal,
  output logic            busy,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ITER = 2'd1, S_DONE = 2'd2} state_e;
  // Ordering matters: the MUL and DIV families are contiguous ranges.
  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU, OP_ILL
  } op_e;

  localparam logic [SHW-1:0]  CNT_LAST = SHW'(XLEN - 1);
  localparam logic [XLEN-1:0] SMIN     = {1'b1, {(XLEN-1){1'b0}}};

  state_e state_q, state_d;
  op_e    op_dec, op_q;
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   b_q, result_q;
  logic [SHW-1:0]    cnt_q;
  logic              sa_q, sb_q, zero_q, ill_q;

  logic            accept, dec_mul, dec_div, early, go_iter, a_sgn, b_sgn, sa, sb;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] simple_res, a_mag, b_mag;

  // ---------------- decode ----------------
  always_comb begin
    op_dec = OP_ILL;
    unique case (alu_op)
      2'b00: begin
        unique case (func3)
          3'b000: op_dec = OP_ADD;
          3'b001: op_dec = OP_SLL;
          3'b010: op_dec = OP_SLT;
          3'b011: op_dec = OP_SLTU;
          3'b100: op_dec = OP_XOR;
          3'b101: op_dec = func7[5] ? OP_SRA : OP_SRL;
          3'b110: op_dec = OP_OR;
          default: op_dec = OP_AND;
        endcase
      end
      2'b01: op_dec = OP_SUB;
      2'b10: begin
        if (func7 == 7'b0000000) begin
          unique case (func3)
            3'b000: op_dec = OP_ADD;
            3'b001: op_dec = OP_SLL;
            3'b010: op_dec = OP_SLT;
            3'b011: op_dec = OP_SLTU;
            3'b100: op_dec = OP_XOR;
            3'b101: op_dec = OP_SRL;
            3'b110: op_dec = OP_OR;
            default: op_dec = OP_AND;
          endcase
        end else if (func7 == 7'b0100000) begin
          if (func3 == 3'b000)      op_dec = OP_SUB;
          else if (func3 == 3'b101) op_dec = OP_SRA;
        end else if (func7 == 7'b0000001) begin
          op_dec = op_e'(5'(OP_MUL) + 5'(func3));
        end
      end
      default: op_dec = OP_ILL;
    endcase
  end

  assign accept  = in_valid & in_ready;
  assign shamt   = op_b[SHW-1:0];
  assign dec_mul = op_dec inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
  assign dec_div = op_dec inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  assign a_sgn   = op_dec inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  assign b_sgn   = op_dec inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  // Divide by zero always short-circuits; overflow only for the signed pair.
  assign early   = dec_div & ((op_b == '0) |
                   (b_sgn & (op_a == SMIN) & (op_b == '1)));
  assign go_iter = dec_mul | (dec_div & ~early);
  assign sa      = a_sgn & op_a[XLEN-1];
  assign sb      = b_sgn & op_b[XLEN-1];
  // -SMIN wraps to SMIN, which is the correct unsigned magnitude.
  assign a_mag   = sa ? -op_a : op_a;
  assign b_mag   = sb ? -op_b : op_b;

  always_comb begin
    simple_res = '0;
    unique case (op_dec)
      OP_ADD:  simple_res = op_a + op_b;
      OP_SUB:  simple_res = op_a - op_b;
      OP_SLL:  simple_res = op_a << shamt;
      OP_SLT:  simple_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      OP_SLTU: simple_res = {{(XLEN-1){1'b0}}, op_a < op_b};
      OP_XOR:  simple_res = op_a ^ op_b;
      OP_SRL:  simple_res = op_a >> shamt;
      OP_SRA:  simple_res = XLEN'($signed(op_a) >>> shamt);
      OP_OR:   simple_res = op_a | op_b;
      OP_AND:  simple_res = op_a & op_b;
      OP_DIV:  simple_res = (op_b == '0) ? '1 : op_a;
      OP_DIVU: simple_res = '1;
      OP_REM:  simple_res = (op_b == '0) ? op_a : '0;
      OP_REMU: simple_res = op_a;
      default: simple_res = '0;
    endcase
  end

  // ---------------- iterative datapath ----------------
  // acc_q holds {high, low}: for MUL the partial product over the shifting
  // multiplier, for DIV the partial remainder over the shifting dividend.
  logic              iter_mul;
  logic [XLEN:0]     mul_sum, div_shift, div_rem;
  logic              div_ge;
  logic [2*XLEN-1:0] acc_next, prod_s;
  logic [XLEN-1:0]   quot_s, rem_s, final_res;

  assign iter_mul  = op_q inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
  assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
  assign div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign div_ge    = div_shift >= {1'b0, b_q};
  assign div_rem   = div_ge ? (div_shift - {1'b0, b_q}) : div_shift;
  assign acc_next  = iter_mul ? {mul_sum, acc_q[XLEN-1:1]}
                              : {div_rem[XLEN-1:0], acc_q[XLEN-2:0], div_ge};
  assign prod_s    = (sa_q ^ sb_q) ? -acc_next : acc_next;
  assign quot_s    = (sa_q ^ sb_q) ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
  assign rem_s     = sa_q ? -acc_next[2*XLEN-1:XLEN] : acc_next[2*XLEN-1:XLEN];

  always_comb begin
    final_res = '0;
    unique case (op_q)
      OP_MUL:                       final_res = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              final_res = quot_s;
      OP_REM, OP_REMU:              final_res = rem_s;
      default:                      final_res = '0;
    endcase
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = go_iter ? S_ITER : S_DONE;
      S_ITER:  if (cnt_q == CNT_LAST) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    busy      = (state_q == S_ITER);
    out_valid = (state_q == S_DONE);
    dbg_state = state_q;
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= OP_ILL;
      acc_q    <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      ill_q    <= 1'b0;
    end else if (state_q == S_IDLE && accept) begin
      op_q  <= op_dec;
      acc_q <= {{XLEN{1'b0}}, a_mag};
      b_q   <= b_mag;
      cnt_q <= '0;
      sa_q  <= sa;
      sb_q  <= sb;
      if (!go_iter) begin
        result_q <= simple_res;
        zero_q   <= (simple_res == '0);
        ill_q    <= (op_dec == OP_ILL);
      end
    end else if (state_q == S_ITER) begin
      acc_q <= acc_next;
      cnt_q <= cnt_q + 1'b1;
      // Sign is applied on the last step, using that step's result.
      if (cnt_q == CNT_LAST) begin
        result_q <= final_res;
        zero_q   <= (final_res == '0);
        ill_q    <= 1'b0;
      end
    end
  end

  assign out_result  = result_q;
  assign out_zero    = zero_q;
  assign out_illegal = ill_q;

endmodule

// File: tb/tb_alu_mdu_unit.sv
module tb_alu_mdu_unit;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [1:0]      alu_op = '0;
  logic [6:0]      func7 = '0;
  logic [2:0]      func3 = '0;
  logic [XLEN-1:0] op_a = '0;
  logic [XLEN-1:0] op_b = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] out_result;
  logic            out_zero;
  logic            out_illegal;
  logic            busy;
  logic [1:0]      dbg_state;

  int n_vec  = 0;
  int n_fail = 0;

  alu_mdu_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .func7(func7), .func3(func3), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_illegal(out_illegal), .busy(busy),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard check ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic ref_model(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] r, output logic ill, output int lat);
    int sa, sb, sra_v;
    longint p;
    logic [63:0] u;
    logic [4:0] sh;
    bit dz, ovf;
    sa = $signed(a); sb = $signed(b); sh = b[4:0];
    r = '0; ill = 1'b0; lat = 1;
    dz  = (b == 32'd0);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    sra_v = sa >>> sh;
    if (op == 2'b01) r = a - b;
    else if (op == 2'b00 || (op == 2'b10 && f7 == 7'h00)) begin
      case (f3)
        3'd0: r = a + b;
        3'd1: r = a << sh;
        3'd2: r = (sa < sb) ? 32'd1 : 32'd0;
        3'd3: r = (a < b) ? 32'd1 : 32'd0;
        3'd4: r = a ^ b;
        3'd5: r = (op == 2'b00 && f7[5]) ? sra_v : (a >> sh);
        3'd6: r = a | b;
        default: r = a & b;
      endcase
    end
    else if (op == 2'b10 && f7 == 7'h20 && f3 == 3'd0) r = a - b;
    else if (op == 2'b10 && f7 == 7'h20 && f3 == 3'd5) r = sra_v;
    else if (op == 2'b10 && f7 == 7'h01) begin
      case (f3)
        3'd0: begin p = longint'(sa) * longint'(sb); r = p[31:0]; lat = 33; end
        3'd1: begin p = longint'(sa) * longint'(sb); r = p[63:32]; lat = 33; end
        3'd2: begin p = longint'(sa) * longint'({32'd0, b}); r = p[63:32]; lat = 33; end
        3'd3: begin u = {32'd0, a} * {32'd0, b}; r = u[63:32]; lat = 33; end
        3'd4: if (dz) r = '1; else if (ovf) r = a; else begin r = sa / sb; lat = 33; end
        3'd5: if (dz) r = '1; else begin r = a / b; lat = 33; end
        3'd6: if (dz) r = a; else if (ovf) r = '0; else begin r = sa % sb; lat = 33; end
        default: if (dz) r = a; else begin r = a % b; lat = 33; end
      endcase
    end
    else ill = 1'b1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b);
    int g = 0;
    @(negedge clk);
    while (!in_ready && g < 100) begin @(negedge clk); g++; end
    chk("in_ready_idle", in_ready, 1);
    alu_op = op; func7 = f7; func3 = f3; op_a = a; op_b = b; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Called on the first negedge after accept; counts cycles to out_valid.
  task automatic wait_done(input string tag, input int exp_lat);
    int cyc = 1, bcnt = 0;
    while (!out_valid && cyc < 80) begin
      if (busy) bcnt++;
      chk({tag, "_in_ready_busy"}, in_ready, 0);
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_latency"}, cyc, exp_lat);
    chk({tag, "_busy_cycles"}, bcnt, exp_lat - 1);
  endtask

  task automatic retire(input string tag, input logic [31:0] exp_r, input logic exp_ill);
    chk({tag, "_out_valid"}, out_valid, 1);
    chk({tag, "_result"}, out_result, exp_r);
    chk({tag, "_zero"}, out_zero, (exp_r == 32'd0));
    chk({tag, "_illegal"}, out_illegal, exp_ill);
    chk({tag, "_in_ready_done"}, in_ready, 0);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, out_valid, 0);
    chk({tag, "_result_hold"}, out_result, exp_r);
    chk({tag, "_in_ready_back"}, in_ready, 1);
  endtask

  task automatic run(input string tag, input logic [1:0] op, input logic [6:0] f7,
                     input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp_r, input logic exp_ill, input int exp_lat);
    issue(op, f7, f3, a, b);
    wait_done(tag, exp_lat);
    retire(tag, exp_r, exp_ill);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] mr;
    logic        mi;
    int          ml;
    logic [1:0]  rop;
    logic [6:0]  rf7;
    logic [2:0]  rf3;
    logic [31:0] ra, rb;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", out_result, 0);
    chk("rst_zero", out_zero, 0);
    chk("rst_illegal", out_illegal, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);

    // simple ALU ops
    run("add",     2'b10, 7'h00, 3'd0, 32'd5, 32'd7, 32'd12, 1'b0, 1);
    run("br_sub",  2'b01, 7'h55, 3'd3, 32'h1234, 32'h1234, 32'd0, 1'b0, 1);
    run("sltu",    2'b10, 7'h00, 3'd3, 32'd1, 32'hFFFF_FFFF, 32'd1, 1'b0, 1);
    run("slt",     2'b10, 7'h00, 3'd2, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1);
    run("sra",     2'b10, 7'h20, 3'd5, 32'h8000_0000, 32'h24, 32'hF800_0000, 1'b0, 1);
    run("srai",    2'b00, 7'h20, 3'd5, 32'h8000_0000, 32'h24, 32'hF800_0000, 1'b0, 1);
    run("srli",    2'b00, 7'h00, 3'd5, 32'h8000_0000, 32'h24, 32'h0800_0000, 1'b0, 1);
    run("slli",    2'b00, 7'h00, 3'd1, 32'd1, 32'd31, 32'h8000_0000, 1'b0, 1);
    run("xori_f7", 2'b00, 7'h5F, 3'd4, 32'hF0F0, 32'h0FF0, 32'hFF00, 1'b0, 1);
    run("ill_op3", 2'b11, 7'h00, 3'd0, 32'd9, 32'd9, 32'd0, 1'b1, 1);
    run("ill_f7",  2'b10, 7'h20, 3'd1, 32'd9, 32'd9, 32'd0, 1'b1, 1);

    // multiply family
    run("mulh",    2'b10, 7'h01, 3'd1, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 1'b0, 33);
    run("mulhu",   2'b10, 7'h01, 3'd3, 32'hFFFF_FFFF, 32'd2, 32'd1, 1'b0, 33);
    run("mul",     2'b10, 7'h01, 3'd0, 32'h1_0000, 32'h1_0000, 32'd0, 1'b0, 33);
    run("mulhsu",  2'b10, 7'h01, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 33);

    // divide family and early-outs
    run("div_z",   2'b10, 7'h01, 3'd4, 32'd7, 32'd0, 32'hFFFF_FFFF, 1'b0, 1);
    run("rem_z",   2'b10, 7'h01, 3'd6, 32'd7, 32'd0, 32'd7, 1'b0, 1);
    run("divu_z",  2'b10, 7'h01, 3'd5, 32'd7, 32'd0, 32'hFFFF_FFFF, 1'b0, 1);
    run("remu_z",  2'b10, 7'h01, 3'd7, 32'd7, 32'd0, 32'd7, 1'b0, 1);
    run("div_ovf", 2'b10, 7'h01, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1);
    run("rem_ovf", 2'b10, 7'h01, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 1);
    run("div_neg", 2'b10, 7'h01, 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 33);
    run("rem_neg", 2'b10, 7'h01, 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 33);
    run("divu",    2'b10, 7'h01, 3'd5, 32'd100, 32'd7, 32'd14, 1'b0, 33);
    run("remu",    2'b10, 7'h01, 3'd7, 32'd100, 32'd7, 32'd2, 1'b0, 33);

    // backpressure: result stable, competing request not accepted
    issue(2'b10, 7'h00, 3'd0, 32'd3, 32'd4);
    wait_done("bp", 1);
    alu_op = 2'b10; func7 = 7'h00; func3 = 3'd4; op_a = 32'hAAAA; op_b = 32'h5555;
    in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_result", out_result, 32'd7);
      chk("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    retire("bp", 32'd7, 1'b0);

    // reset in the middle of an iterative divide
    issue(2'b10, 7'h01, 3'd5, 32'd1000, 32'd7);
    repeat (9) @(negedge clk);
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_result", out_result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_rel_in_ready", in_ready, 1);
    @(negedge clk);
    chk("mid_rel_valid", out_valid, 0);

    // randomized traffic against the reference model
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 4))
        0: rf7 = 7'h00;
        1: rf7 = 7'h20;
        2, 3: rf7 = 7'h01;
        default: rf7 = 7'($urandom_range(0, 127));
      endcase
      if ($urandom_range(0, 1) == 1) rop = 2'b10;
      rf3 = 3'($urandom_range(0, 7));
      ra  = pick_operand();
      rb  = pick_operand();
      ref_model(rop, rf7, rf3, ra, rb, mr, mi, ml);
      run("rand", rop, rf7, rf3, ra, rb, mr, mi, ml);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
